ethii_tx_arbiter: RTL and testbench

- Packet-level arbiter sharing one Ethernet II transmit packer between N_PORTS requesters, e.g. the UDP/IP path and the ARP responder.
- Each requester presents a MAC header handshake plus a 32-bit user stream.
- The arbiter grants one requester, forwards its header and then its whole packet to the packer's header/user inputs, and releases on tlast.
- Sits directly in front of the packer in the TX path.

---
 rtl/ethii_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_ethii_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethii_tx_arbiter.sv
// Packet-level arbiter sharing one Ethernet II TX packer among N_PORTS requesters.
// Define ETHII_ARB_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ethii_tx_arbiter #(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_PORTS*48-1:0] req_mac_dest_i,
  input  logic [N_PORTS*48-1:0] req_mac_src_i,
  input  logic [N_PORTS-1:0]    req_mac_vld_i,
  output logic [N_PORTS-1:0]    req_mac_rdy_o,
  input  logic [N_PORTS*32-1:0] req_tdata_i,
  input  logic [N_PORTS*4-1:0]  req_tkeep_i,
  input  logic [N_PORTS-1:0]    req_tlast_i,
  input  logic [N_PORTS-1:0]    req_tvld_i,
  output logic [N_PORTS-1:0]    req_trdy_o,
  output logic [47:0]           hdr_mac_dest_o,
  output logic [47:0]           hdr_mac_src_o,
  output logic                  hdr_mac_vld_o,
  input  logic                  hdr_mac_rdy_i,
  output logic [31:0]           user_tdata_o,
  output logic [3:0]            user_tkeep_o,
  output logic                  user_tlast_o,
  output logic                  user_tvld_o,
  input  logic                  user_trdy_i,
  output logic [PTR_W-1:0]      grant_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W-1:0] win;
  logic             any_req;
  logic             in_hdr, in_data;
  logic             hdr_hs, last_beat;

  assign in_hdr  = (state_q == HDR);
  assign in_data = (state_q == DATA);
  assign any_req = |req_mac_vld_i;

  // Later loop iterations overwrite earlier ones, so the highest-priority
  // candidate is visited last.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
`ifdef ETHII_ARB_STRICT_PRIO_EN
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req_mac_vld_i[i]) win = PTR_W'(i);
    end
`else
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last_q) + i) % N_PORTS;
      if (req_mac_vld_i[idx]) win = PTR_W'(idx);
    end
`endif
  end

  assign hdr_hs    = in_hdr && req_mac_vld_i[grant_q] && hdr_mac_rdy_i;
  assign last_beat = in_data && req_tvld_i[grant_q] && user_trdy_i
                     && req_tlast_i[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
          state_d = HDR;
        end
      end
      HDR: begin
        if (hdr_hs) begin
          last_d  = grant_q;
          state_d = DATA;
        end
      end
      DATA: begin
        if (last_beat) begin
          if (any_req) begin
            grant_d = win;
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PTR_W'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    req_mac_rdy_o = '0;
    req_trdy_o    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q == PTR_W'(i)) begin
        req_mac_rdy_o[i] = in_hdr && hdr_mac_rdy_i;
        req_trdy_o[i]    = in_data && user_trdy_i;
      end
    end
  end

  assign hdr_mac_dest_o = in_hdr ? req_mac_dest_i[int'(grant_q)*48 +: 48] : '0;
  assign hdr_mac_src_o  = in_hdr ? req_mac_src_i[int'(grant_q)*48 +: 48] : '0;
  assign hdr_mac_vld_o  = in_hdr && req_mac_vld_i[grant_q];

  assign user_tdata_o = in_data ? req_tdata_i[int'(grant_q)*32 +: 32] : '0;
  assign user_tkeep_o = in_data ? req_tkeep_i[int'(grant_q)*4 +: 4] : '0;
  assign user_tlast_o = in_data && req_tlast_i[grant_q];
  assign user_tvld_o  = in_data && req_tvld_i[grant_q];

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_ethii_tx_arbiter.sv
// Directed self-checking bench for ethii_tx_arbiter (N_PORTS=2).
// Covers single port, round-robin, backpressure, back-to-back and mid-packet reset.
module tb_ethii_tx_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N*48-1:0] mdest, msrc;
  logic [N-1:0]    mvld, mrdy;
  logic [N*32-1:0] tdata;
  logic [N*4-1:0]  tkeep;
  logic [N-1:0]    tlast, tvld, trdy;
  logic [47:0]     hdr_mac_dest_o, hdr_mac_src_o;
  logic            hdr_mac_vld_o, hdr_rdy;
  logic [31:0]     user_tdata_o;
  logic [3:0]      user_tkeep_o;
  logic            user_tlast_o, user_tvld_o, utrdy;
  logic [0:0]      grant_o;
  logic            busy_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] pkt[8];
  logic [3:0]  last_keep;

  ethii_tx_arbiter #(.N_PORTS(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_mac_dest_i (mdest),
    .req_mac_src_i  (msrc),
    .req_mac_vld_i  (mvld),
    .req_mac_rdy_o  (mrdy),
    .req_tdata_i    (tdata),
    .req_tkeep_i    (tkeep),
    .req_tlast_i    (tlast),
    .req_tvld_i     (tvld),
    .req_trdy_o     (trdy),
    .hdr_mac_dest_o (hdr_mac_dest_o),
    .hdr_mac_src_o  (hdr_mac_src_o),
    .hdr_mac_vld_o  (hdr_mac_vld_o),
    .hdr_mac_rdy_i  (hdr_rdy),
    .user_tdata_o   (user_tdata_o),
    .user_tkeep_o   (user_tkeep_o),
    .user_tlast_o   (user_tlast_o),
    .user_tvld_o    (user_tvld_o),
    .user_trdy_i    (utrdy),
    .grant_o        (grant_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    mvld    = '0;
    tvld    = '0;
    tlast   = '0;
    hdr_rdy = 1'b1;
    utrdy   = 1'b1;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic set_beat(input int p, input logic [31:0] d,
                          input logic [3:0] k, input logic l, input logic v);
    tdata[p*32 +: 32] = d;
    tkeep[p*4 +: 4]   = k;
    tlast[p]          = l;
    tvld[p]           = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_grant"}, grant_o, 0);
    check({tag, "_hvld"}, hdr_mac_vld_o, 0);
    check({tag, "_mrdy"}, mrdy, 0);
    check({tag, "_tvld"}, user_tvld_o, 0);
    check({tag, "_tlast"}, user_tlast_o, 0);
    check({tag, "_trdy"}, trdy, 0);
  endtask

  // Ends at a negedge with the DUT expected to be in HDR for port exp_g.
  task automatic wait_hdr(input string tag, input int exp_g, output int n);
    logic [N-1:0] e;
    e = '0;
    e[exp_g] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!hdr_mac_vld_o && n < 8) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_hvld"}, hdr_mac_vld_o, 1);
    check({tag, "_grant"}, grant_o, exp_g);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_mrdy"}, mrdy, e);
    check({tag, "_dest"}, hdr_mac_dest_o, mdest[exp_g*48 +: 48]);
    check({tag, "_src"}, hdr_mac_src_o, msrc[exp_g*48 +: 48]);
  endtask

  task automatic send(input string tag, input int p, input int len,
                      input bit rereq, input bit toggle);
    int           beats;
    int           cyc;
    bit           fire;
    bit           done;
    logic [N-1:0] et;
    beats = 0;
    cyc   = 0;
    done  = 0;
    tick;
    if (!rereq) mvld[p] = 1'b0;
    set_beat(p, pkt[0], (len == 1) ? last_keep : 4'hF, len == 1, 1'b1);
    while (!done && cyc < 4*len + 8) begin
      utrdy = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      check({tag, "_data"}, user_tdata_o, pkt[beats]);
      check({tag, "_keep"}, user_tkeep_o,
            (beats == len-1) ? last_keep : 4'hF);
      check({tag, "_last"}, user_tlast_o, beats == len-1);
      et = '0;
      if (utrdy) et[p] = 1'b1;
      check({tag, "_trdy"}, trdy, et);
      fire = user_tvld_o && utrdy;
      done = fire && user_tlast_o;
      tick;
      cyc++;
      if (fire) begin
        beats++;
        if (beats < len)
          set_beat(p, pkt[beats], (beats == len-1) ? last_keep : 4'hF,
                   beats == len-1, 1'b1);
        else
          set_beat(p, '0, '0, 1'b0, 1'b0);
      end
    end
    check({tag, "_beats"}, beats, len);
    utrdy = 1'b1;
  endtask

  initial begin
    int n;
    int exp;
    mdest = '0;
    msrc  = '0;
    mvld  = '0;
    tdata = '0;
    tkeep = '0;
    tlast = '0;
    tvld  = '0;
    hdr_rdy = 1'b1;
    utrdy   = 1'b1;
    mdest[0 +: 48]  = 48'h0A0B0C0D0E0F;
    msrc[0 +: 48]   = 48'h102030405060;
    mdest[48 +: 48] = 48'h112233445566;
    msrc[48 +: 48]  = 48'hAABBCCDDEEFF;

    // single port 1, 3 beats
    do_reset;
    @(negedge clk);
    check_idle("rst");
    tick;
    mvld[1] = 1'b1;
    pkt[0] = 32'hA1A2A3A4;
    pkt[1] = 32'hB1B2B3B4;
    pkt[2] = 32'hC1C2C3C4;
    last_keep = 4'b1100;
    wait_hdr("t1", 1, n);
    check("t1_lat", n, 1);
    send("t1", 1, 3, 0, 0);
    @(negedge clk);
    check("t1_busy_end", busy_o, 0);
    check("t1_tvld_end", user_tvld_o, 0);

    // both ports request continuously
    do_reset;
    mvld = '1;
    last_keep = 4'hF;
    for (int k = 0; k < 4; k++) begin
`ifdef ETHII_ARB_STRICT_PRIO_EN
      exp = 0;
`else
      exp = k % 2;
`endif
      pkt[0] = 32'h5000_0000 | (k << 8) | (exp << 4);
      pkt[1] = pkt[0] + 1;
      wait_hdr($sformatf("rr%0d", k), exp, n);
      check($sformatf("rr%0d_lat", k), n, (k == 0) ? 1 : 0);
      send($sformatf("rr%0d", k), exp, 2, 1, 0);
    end

    // backpressure, 5 beats, trdy 1010
    do_reset;
    tick;
    mvld[0] = 1'b1;
    for (int i = 0; i < 5; i++) pkt[i] = 32'hD000_0000 + i;
    last_keep = 4'b0111;
    wait_hdr("bp", 0, n);
    send("bp", 0, 5, 0, 1);
    @(negedge clk);
    check("bp_busy_end", busy_o, 0);

    // back-to-back: port 1 requests while port 0 is active
    do_reset;
    tick;
    mvld[0] = 1'b1;
    for (int i = 0; i < 3; i++) pkt[i] = 32'hE000_0000 + i;
    last_keep = 4'hF;
    wait_hdr("b2b0", 0, n);
    mvld[1] = 1'b1;
    send("b2b0", 0, 3, 0, 0);
    pkt[0] = 32'hF0F0F0F0;
    pkt[1] = 32'h0F0F0F0F;
    wait_hdr("b2b1", 1, n);
    check("b2b_noidle", n, 0);
    send("b2b1", 1, 2, 0, 0);
    @(negedge clk);
    check("b2b_busy_end", busy_o, 0);

    // reset during DATA on beat 2
    do_reset;
    tick;
    mvld[0] = 1'b1;
    pkt[0] = 32'h12345678;
    pkt[1] = 32'h9ABCDEF0;
    wait_hdr("mr0", 0, n);
    tick;
    mvld[0] = 1'b0;
    set_beat(0, pkt[0], 4'hF, 1'b0, 1'b1);
    tick;
    set_beat(0, pkt[1], 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    check("mr_beat2", user_tdata_o, pkt[1]);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    set_beat(0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_idle("mr");
    tick;
    mvld[1] = 1'b1;
    pkt[0] = 32'h55AA55AA;
    pkt[1] = 32'hAA55AA55;
    wait_hdr("mr1", 1, n);
    check("mr1_lat", n, 1);
    send("mr1", 1, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
